// File: rtl/scb_pkg_pip1.sv
// Shared constants, types and helpers for the pip1 scoreboard slice.
package scb_pkg_pip1;

  localparam int N_cell  = 8;
  localparam int W_ident = 4;
  localparam int W_pip   = 2;
  localparam int W_PA_rx = 5;
  localparam int W_state = 7;
  localparam int D_res   = 16;
  localparam int W_lat   = 4;

  // Reservation table length: horizon plus the two-cycle issue-to-count offset.
  localparam int W_res   = D_res + 2;
  localparam int W_slot  = $clog2(W_res);

  localparam logic [W_ident-1:0] unused_cd = {W_ident{1'b1}};
  localparam logic [W_pip-1:0]   V_pip0    = 2'b01;
  localparam logic [W_pip-1:0]   V_pip1    = 2'b10;

  // Registered insert bus driven into the cell array.
  typedef struct packed {
    logic [W_ident-1:0] addr;
    logic [W_pip-1:0]   pip;
    logic [W_PA_rx-1:0] rd;
    logic [W_state-1:0] state;
  } ins_bus_t;

  // Only the two one-hot pipe codes name a real writeback port.
  function automatic logic pip_is_legal(input logic [W_pip-1:0] pip);
    return (pip == V_pip0) || (pip == V_pip1);
  endfunction

  // One-hot reservation bit at position lat+ofs.
  function automatic logic [W_res-1:0] res_onehot(input logic [W_lat-1:0]  lat,
                                                  input logic [W_slot-1:0] ofs);
    logic [W_res-1:0] v;
    v = {{(W_res-1){1'b0}}, 1'b1} << (W_slot'(lat) + ofs);
    return v;
  endfunction

endpackage

// File: rtl/scb_minsel_pip1.sv
// Minimum-index reducer: returns the lowest lane that carries a real index and
// is enabled by the mask, or all-ones when no lane qualifies.
module scb_minsel_pip1 #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic [N*W-1:0] i_lanes,
  input  logic [N-1:0]   i_mask,
  output logic [W-1:0]   o_idx,
  output logic           o_found
);

  logic [N-1:0] w_sel;
  logic [W-1:0] w_idx;
  logic         w_found;

  // A lane competes when it advertises an index and is not masked off.
  always_comb begin
    w_sel = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      w_sel[i] = (i_lanes[i*W +: W] != {W{1'b1}}) && i_mask[i];
    end
  end

  // Downward scan so the last hit written is the lowest selectable index.
  always_comb begin
    w_idx   = {W{1'b1}};
    w_found = 1'b0;
    for (int i = N-1; i >= 0; i--) begin
      w_idx   = w_sel[i] ? W'(i) : w_idx;
      w_found = w_found | w_sel[i];
    end
  end

  assign o_idx   = w_idx;
  assign o_found = w_found;

endmodule

// File: rtl/scb_alloc_pip1.sv
// Insert-side allocator: picks the lowest free cell, reserves the writeback
// slot on the target pipe port and drives the registered insert bus.
module scb_alloc_pip1
  import scb_pkg_pip1::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      CFI_PC_clear,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [W_pip-1:0]          req_pip,
  input  logic [W_PA_rx-1:0]        req_rd,
  input  logic [W_lat-1:0]          req_lat,
  input  logic [N_cell*W_ident-1:0] candit_insert,
  output logic [W_ident-1:0]        addr_insert,
  output logic [W_pip-1:0]          i_pip,
  output logic [W_PA_rx-1:0]        i_rd_a,
  output logic [W_state-1:0]        i_state,
  output logic                      full
);

  logic [W_res-1:0]   r_res0;
  logic [W_res-1:0]   r_res1;
  logic [W_ident-1:0] r_pend_idx;
  ins_bus_t           r_ins;

  logic [N_cell-1:0]  w_mask;
  logic [W_ident-1:0] w_sel_idx;
  logic               w_found;
  logic [W_slot-1:0]  w_slot;
  logic               w_slot_free;
  logic               w_ready;
  logic               w_accept;
  logic [W_res-1:0]   w_res_add;
  logic [W_res-1:0]   w_res0_nxt;
  logic [W_res-1:0]   w_res1_nxt;
  logic [W_ident-1:0] w_pend_nxt;
  ins_bus_t           w_ins_nxt;

  // The cell issued last cycle does not show INUSED yet, so keep it out.
  always_comb begin
    w_mask = {N_cell{1'b0}};
    for (int i = 0; i < N_cell; i++) begin
      w_mask[i] = (W_ident'(i) != r_pend_idx);
    end
  end

  scb_minsel_pip1 #(
    .N (N_cell),
    .W (W_ident)
  ) u_minsel (
    .i_lanes (candit_insert),
    .i_mask  (w_mask),
    .o_idx   (w_sel_idx),
    .o_found (w_found)
  );

  // Writeback lands at t+2+lat, i.e. bit lat+2 of the table seen this cycle.
  assign w_slot    = W_slot'(req_lat) + W_slot'(2);
  // After this cycle's shift the same writeback sits one bit lower.
  assign w_res_add = res_onehot(req_lat, W_slot'(1));

  // Slot lookup on the requested port; an illegal pipe code never finds a slot.
  always_comb begin
    w_slot_free = 1'b0;
    case (req_pip)
      V_pip0:  w_slot_free = ~r_res0[w_slot];
      V_pip1:  w_slot_free = ~r_res1[w_slot];
      default: w_slot_free = 1'b0;
    endcase
  end

  assign w_ready   = rst_n & ~CFI_PC_clear & w_found & w_slot_free & pip_is_legal(req_pip);
  assign w_accept  = req_valid & w_ready;
  assign req_ready = w_ready;
  assign full      = ~w_found;

  // Next reservation tables: age by one cycle, add the new slot, or flush.
  always_comb begin
    w_res0_nxt = {1'b0, r_res0[W_res-1:1]};
    w_res1_nxt = {1'b0, r_res1[W_res-1:1]};
    if (CFI_PC_clear) begin
      w_res0_nxt = {W_res{1'b0}};
      w_res1_nxt = {W_res{1'b0}};
    end else if (w_accept) begin
      case (req_pip)
        V_pip0:  w_res0_nxt = w_res0_nxt | w_res_add;
        V_pip1:  w_res1_nxt = w_res1_nxt | w_res_add;
        default: w_res0_nxt = w_res0_nxt;
      endcase
    end else begin
      w_res0_nxt = w_res0_nxt;
    end
  end

  // Next insert bus and pending index; payload fields hold when idle.
  always_comb begin
    w_ins_nxt  = r_ins;
    w_pend_nxt = unused_cd;
    if (w_accept) begin
      w_ins_nxt.addr  = w_sel_idx;
      w_ins_nxt.pip   = req_pip;
      w_ins_nxt.rd    = req_rd;
      w_ins_nxt.state = {{(W_state-W_lat){1'b0}}, req_lat};
      w_pend_nxt      = w_sel_idx;
    end else begin
      w_ins_nxt.addr  = unused_cd;
      w_pend_nxt      = unused_cd;
    end
  end

  // State registers: reservation tables, pending cell and insert bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res0       <= {W_res{1'b0}};
      r_res1       <= {W_res{1'b0}};
      r_pend_idx   <= unused_cd;
      r_ins.addr   <= unused_cd;
      r_ins.pip    <= {W_pip{1'b0}};
      r_ins.rd     <= {W_PA_rx{1'b0}};
      r_ins.state  <= {W_state{1'b0}};
    end else begin
      r_res0       <= w_res0_nxt;
      r_res1       <= w_res1_nxt;
      r_pend_idx   <= w_pend_nxt;
      r_ins        <= w_ins_nxt;
    end
  end

  assign addr_insert = r_ins.addr;
  assign i_pip       = r_ins.pip;
  assign i_rd_a      = r_ins.rd;
  assign i_state     = r_ins.state;

endmodule
